// File: rtl/seq_chunk_feeder.sv
// Packs a 2-bit symbol stream into PE_SIZE-lane chunks and hands them to the
// PE array on request through a 2-entry chunk FIFO.
module seq_chunk_feeder #(
  parameter int PE_SIZE = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  input  logic [1:0]           in_data,
  input  logic                 in_last,
  output logic                 in_ready,
  input  logic                 request,
  output logic [PE_SIZE*2-1:0] out_data,
  output logic [PE_SIZE-1:0]   out_valid,
  output logic                 out_last
);

  localparam int IW = (PE_SIZE > 1) ? $clog2(PE_SIZE) : 1;
  localparam logic [IW-1:0] IdxLast = IW'(PE_SIZE - 1);

  logic [PE_SIZE*2-1:0] asmData;
  logic [IW-1:0]        idx;

  logic [PE_SIZE*2-1:0] fData [2];
  logic [PE_SIZE-1:0]   fMask [2];
  logic                 fLast [2];
  logic                 rdPtr;
  logic                 wrPtr;
  logic [1:0]           count;
  logic                 pending;

  logic                 accept;
  logic                 closeChunk;
  logic                 popNow;
  logic [PE_SIZE*2-1:0] asmNext;
  logic [PE_SIZE-1:0]   maskNext;

  assign in_ready   = (count != 2'd2);
  assign accept     = in_valid && in_ready;
  assign closeChunk = accept && (in_last || idx == IdxLast);
  // count is sampled before any same-edge commit
  assign popNow     = (request || pending) && (count != 2'd0);

  always_comb begin
    asmNext = asmData;
    asmNext[{idx, 1'b0} +: 2] = in_data;
    maskNext = '0;
    for (int i = 0; i < PE_SIZE; i++) begin
      maskNext[i] = (i <= int'(idx));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      asmData   <= '0;
      idx       <= '0;
      rdPtr     <= 1'b0;
      wrPtr     <= 1'b0;
      count     <= 2'd0;
      pending   <= 1'b0;
      out_data  <= '0;
      out_valid <= '0;
      out_last  <= 1'b0;
      for (int i = 0; i < 2; i++) begin
        fData[i] <= '0;
        fMask[i] <= '0;
        fLast[i] <= 1'b0;
      end
    end else begin
      if (accept) begin
        if (closeChunk) begin
          fData[wrPtr] <= asmNext;
          fMask[wrPtr] <= maskNext;
          fLast[wrPtr] <= in_last;
          wrPtr        <= ~wrPtr;
          asmData      <= '0;
          idx          <= '0;
        end else begin
          asmData <= asmNext;
          idx     <= idx + 1'b1;
        end
      end

      if (popNow) begin
        out_data  <= fData[rdPtr];
        out_valid <= fMask[rdPtr];
        out_last  <= fLast[rdPtr];
        rdPtr     <= ~rdPtr;
        pending   <= 1'b0;
      end else if (request && count == 2'd0) begin
        pending   <= 1'b1;
        out_valid <= '0;
      end

      unique case ({closeChunk, popNow})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_chunk_feeder.sv
// Directed bench for seq_chunk_feeder with PE_SIZE=4.
// Inputs change #1 after the rising edge; outputs are sampled there too.
module tb_seq_chunk_feeder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic [1:0] in_data = 2'd0;
  logic       in_last = 1'b0;
  logic       in_ready;
  logic       request = 1'b0;
  logic [7:0] out_data;
  logic [3:0] out_valid;
  logic       out_last;

  int checks = 0;
  int errors = 0;

  seq_chunk_feeder #(.PE_SIZE(4)) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_data(in_data),
    .in_last(in_last),
    .in_ready(in_ready),
    .request(request),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_last(out_last)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] d, input logic l);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = l;
    step();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic req();
    request = 1'b1;
    step();
    request = 1'b0;
  endtask

  task automatic outChk(input string tag, input logic [7:0] d,
                        input logic [3:0] v, input logic l);
    chk({tag, "_data"}, 32'(out_data), 32'(d));
    chk({tag, "_valid"}, 32'(out_valid), 32'(v));
    chk({tag, "_last"}, 32'(out_last), 32'(l));
  endtask

  initial begin
    // reset state
    #1;
    outChk("rst", 8'h00, 4'h0, 1'b0);
    chk("rst_ready", 32'(in_ready), 32'd1);
    step();
    step();
    rst = 1'b0;
    step();

    // full chunk 1,2,3,0 with last
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    push(2'd3, 1'b0);
    push(2'd0, 1'b1);
    chk("full_hold", 32'(out_valid), 32'h0);
    req();
    outChk("full", 8'h39, 4'hF, 1'b1);

    // partial chunk 3,3 with last
    push(2'd3, 1'b0);
    push(2'd3, 1'b1);
    req();
    outChk("part2", 8'h0F, 4'h3, 1'b1);

    // partial chunk of three symbols
    push(2'd2, 1'b0);
    push(2'd1, 1'b0);
    push(2'd3, 1'b1);
    req();
    outChk("part3", 8'h36, 4'h7, 1'b1);

    // request on empty FIFO, then a second one while pending
    req();
    chk("pend_valid0", 32'(out_valid), 32'h0);
    chk("pend_data_hold", 32'(out_data), 32'h36);
    req();
    chk("pend2_valid0", 32'(out_valid), 32'h0);
    push(2'd2, 1'b0);
    push(2'd1, 1'b0);
    push(2'd0, 1'b0);
    push(2'd3, 1'b0);
    chk("pend_commit_edge", 32'(out_valid), 32'h0);
    step();
    outChk("pend_pop", 8'hC6, 4'hF, 1'b0);
    // the second request must not have been remembered
    push(2'd1, 1'b0);
    push(2'd1, 1'b0);
    push(2'd1, 1'b0);
    push(2'd1, 1'b1);
    step();
    step();
    outChk("no_extra_pop", 8'hC6, 4'hF, 1'b0);
    req();
    outChk("after_pend", 8'h55, 4'hF, 1'b1);

    // fill the FIFO: 8 symbols, no requests
    push(2'd0, 1'b0);
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    push(2'd3, 1'b0);
    chk("fill1_ready", 32'(in_ready), 32'd1);
    push(2'd3, 1'b0);
    push(2'd2, 1'b0);
    push(2'd1, 1'b0);
    push(2'd0, 1'b0);
    chk("full_ready0", 32'(in_ready), 32'd0);
    // held symbol must not be accepted while full
    in_valid = 1'b1;
    in_data  = 2'd1;
    step();
    in_valid = 1'b0;
    chk("full_ready0b", 32'(in_ready), 32'd0);
    req();
    chk("drain_ready1", 32'(in_ready), 32'd1);
    outChk("fifoA", 8'hE4, 4'hF, 1'b0);
    push(2'd1, 1'b0);
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    push(2'd2, 1'b0);
    chk("refill_ready0", 32'(in_ready), 32'd0);
    req();
    outChk("fifoB", 8'h1B, 4'hF, 1'b0);
    req();
    outChk("fifoC", 8'hA5, 4'hF, 1'b0);
    chk("empty_ready1", 32'(in_ready), 32'd1);

    // commit and pop on the same edge with count==1
    push(2'd0, 1'b0);
    push(2'd0, 1'b0);
    push(2'd0, 1'b0);
    push(2'd1, 1'b1);
    push(2'd2, 1'b0);
    push(2'd2, 1'b0);
    push(2'd2, 1'b0);
    in_valid = 1'b1;
    in_data  = 2'd2;
    request  = 1'b1;
    step();
    in_valid = 1'b0;
    request  = 1'b0;
    outChk("same_edge", 8'h40, 4'hF, 1'b1);
    chk("same_edge_ready", 32'(in_ready), 32'd1);
    req();
    outChk("same_edge_next", 8'hAA, 4'hF, 1'b0);

    // reset mid-sequence discards partial data
    push(2'd3, 1'b0);
    push(2'd3, 1'b0);
    rst = 1'b1;
    #1;
    outChk("midrst", 8'h00, 4'h0, 1'b0);
    chk("midrst_ready", 32'(in_ready), 32'd1);
    step();
    rst = 1'b0;
    step();
    push(2'd1, 1'b0);
    push(2'd2, 1'b0);
    push(2'd3, 1'b0);
    push(2'd0, 1'b1);
    req();
    outChk("post_rst", 8'h39, 4'hF, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/seq_chunk_feeder.md
SEQ_CHUNK_FEEDER -- requirements
Module: seq_chunk_feeder

Interface
REQ-001 The block SHALL have parameter PE_SIZE, default 8, giving the number of PE lanes (2-bit symbols) per chunk.
REQ-002 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-004 The block SHALL have port in_valid, input, 1 bit: a symbol is present on in_data.
REQ-005 The block SHALL have port in_data, input, 2 bits: nucleotide code.
REQ-006 The block SHALL have port in_last, input, 1 bit: the current symbol ends the sequence.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts a symbol this cycle.
REQ-008 The block SHALL have port request, input, 1 bit: single-cycle pulse from the PE array controller asking for the next chunk.
REQ-009 The block SHALL have port out_data, output, PE_SIZE*2 bits: chunk symbols.
REQ-010 The block SHALL have port out_valid, output, PE_SIZE bits: per-lane valid mask.
REQ-011 The block SHALL have port out_last, output, 1 bit: the presented chunk is the final chunk of its sequence.

Function
REQ-012 The block SHALL accept a symbol on each rising edge where in_valid and in_ready are both 1.
REQ-013 The block SHALL place accepted symbol k (0-based within its chunk) at out_data[2k+1:2k]; lane 0 is the first symbol.
REQ-014 The block SHALL commit the assembling chunk to a 2-entry chunk FIFO on the edge that accepts either the PE_SIZE-th symbol or a symbol with in_last=1.
REQ-015 The committed mask SHALL be (1<<n)-1, where n is the number of symbols in the chunk; the last flag is the in_last value of the closing symbol.
REQ-016 After in_last, the next accepted symbol SHALL start a new chunk at lane 0.
REQ-017 When in_last arrives on exactly the PE_SIZE-th symbol, the block SHALL produce a single full chunk with last=1 and no empty trailing chunk.
REQ-018 in_ready SHALL be combinational and equal to (FIFO count != 2).
REQ-019 If request=1 at an edge where FIFO count>0 (count sampled before any same-edge commit), the block SHALL pop the head and update out_data/out_valid/out_last at that edge, so the result is visible the next cycle.
REQ-020 If request=1 with count==0, the block SHALL set a pending flag and drive out_valid to 0 at that edge.
REQ-021 While pending is set, the block SHALL pop at the first edge with count>0 and clear pending at that edge; presentation then follows one cycle after the commit.
REQ-022 A request while pending is already set SHALL be ignored; pending is not counted.
REQ-023 On a simultaneous commit and pop at the same edge, count SHALL be unchanged and FIFO order SHALL be preserved.
REQ-024 A commit SHALL never occur while count==2; this is guaranteed by REQ-018.
REQ-025 Outputs SHALL hold their value between pops; a pop is the only event that changes out_data or out_last.
REQ-026 Symbol bits in unused lanes of a partial chunk SHALL be 0.

Reset
REQ-027 Asserting rst SHALL immediately clear the FIFO, the assembling chunk, the lane counter and the pending flag.
REQ-028 Asserting rst SHALL immediately set out_data=0, out_valid=0 and out_last=0, and make in_ready=1 once rst is asserted.
REQ-029 Assertion of rst mid-sequence SHALL discard all partial and buffered data; after release the next accepted symbol starts a new chunk at lane 0.

Verification (PE_SIZE=4)
REQ-030 Push symbols 1,2,3,0 with in_last on the last symbol, then pulse request -> next cycle out_data=8'b00_11_10_01, out_valid=4'b1111, out_last=1.
REQ-031 Push 3,3 with in_last, then request -> out_data=8'h0F, out_valid=4'b0011, out_last=1.
REQ-032 Pulse request with the FIFO empty -> out_valid=0; then push 4 symbols -> chunk appears one cycle after the commit edge with no further request; a second request while pending has no effect.
REQ-033 Push 12 symbols (no in_last) with no requests -> in_ready=0 after 8 symbols; one request -> in_ready=1 the next cycle; the remaining 4 are accepted, and chunks come out in order on the later requests.
REQ-034 Pulse request on the same edge as a commit with count==1 -> the old head is presented, count stays 1, and the new chunk follows on the next request.
REQ-035 Assert rst after 2 of 4 symbols, release, push 4 symbols with in_last, then request -> only the new 4 symbols are presented with mask 4'b1111.
